// File: rtl/xover_coeff_loader.sv
// -----------------------------------------------------------------------------
// xover_coeff_loader
//
// SPI-slave (mode 0, MSB first) coefficient loader for the audio crossover.
// The host writes biquad coefficients into a shadow bank one frame at a time,
// then sends a COMMIT. The shadow bank is copied to the active bank on the
// next sample-sync pulse, so both IIR channels switch coefficients atomically
// between two samples.
//
// Frame: 8-bit address, then NBITS data bits for addresses 0x00..0x09.
//   0x00..0x04 : lp_a0, lp_a1, lp_a2, lp_b1, lp_b2
//   0x05..0x09 : hp_a0, hp_a1, hp_a2, hp_b1, hp_b2
//   0x80       : COMMIT (no data bits)
//
// Ports:
//   i_mck              system clock, everything on the rising edge
//   i_rst              synchronous active-high reset
//   i_sck/i_csn/i_mosi asynchronous SPI inputs, synchronised internally
//   i_sync             one-cycle sample-valid pulse shared with the IIRs
//   o_lp_* / o_hp_*    active coefficients (two's complement, NBITS wide)
//   o_pending          COMMIT received, waiting for i_sync
//   o_loaded           at least one commit completed since reset
//   o_err              sticky frame error, cleared by reset or a commit
// -----------------------------------------------------------------------------
module xover_coeff_loader #(
  parameter int NBITS       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_mck,
  input  logic             i_rst,
  input  logic             i_sck,
  input  logic             i_csn,
  input  logic             i_mosi,
  input  logic             i_sync,
  output logic [NBITS-1:0] o_lp_a0,
  output logic [NBITS-1:0] o_lp_a1,
  output logic [NBITS-1:0] o_lp_a2,
  output logic [NBITS-1:0] o_lp_b1,
  output logic [NBITS-1:0] o_lp_b2,
  output logic [NBITS-1:0] o_hp_a0,
  output logic [NBITS-1:0] o_hp_a1,
  output logic [NBITS-1:0] o_hp_a2,
  output logic [NBITS-1:0] o_hp_b1,
  output logic [NBITS-1:0] o_hp_b2,
  output logic             o_pending,
  output logic             o_loaded,
  output logic             o_err
);

  localparam int CNT_W = $clog2(NBITS + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ADDR    = 2'd1,
    ST_DATA    = 2'd2,
    ST_WAIT_CS = 2'd3
  } state_t;

  // synchronisers and edge detection
  logic [SYNC_STAGES-1:0] sck_sync_r;
  logic [SYNC_STAGES-1:0] csn_sync_r;
  logic [SYNC_STAGES-1:0] mosi_sync_r;
  logic                   sck_prev_r;
  logic                   csn_prev_r;
  logic                   sck_s;
  logic                   csn_s;
  logic                   mosi_s;
  logic                   sck_rise_s;
  logic                   csn_fall_s;
  logic                   csn_rise_s;

  // frame state
  state_t                 state_r;
  logic [CNT_W-1:0]       bit_cnt_r;
  logic [6:0]             addr_r;     // top address bit is never needed after shifting
  logic [3:0]             idx_r;      // decoded coefficient index for the data phase
  logic [NBITS-2:0]       data_r;     // the last data bit is taken straight from mosi

  // decode helpers
  logic [7:0]             addr_next_s;
  logic [NBITS-1:0]       data_next_s;
  logic                   addr_done_s;
  logic                   commit_dec_s;
  logic                   err_set_s;
  logic                   copy_s;

  // coefficient banks and status
  logic [NBITS-1:0]       shadow_r [0:9];
  logic [NBITS-1:0]       active_r [0:9];
  logic                   pending_r;
  logic                   loaded_r;
  logic                   err_r;

  assign sck_s      = sck_sync_r[SYNC_STAGES-1];
  assign csn_s      = csn_sync_r[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync_r[SYNC_STAGES-1];
  assign sck_rise_s = sck_s & ~sck_prev_r;
  assign csn_fall_s = ~csn_s & csn_prev_r;
  assign csn_rise_s = csn_s & ~csn_prev_r;

  // Synchronise the SPI pins. csn resets to "selected" so that a reset issued
  // mid-frame produces no false falling edge: the remainder of that frame is
  // ignored until the host deselects and selects again.
  always_ff @(posedge i_mck) begin
    if (i_rst) begin
      sck_sync_r  <= '0;
      csn_sync_r  <= '0;
      mosi_sync_r <= '0;
      sck_prev_r  <= 1'b0;
      csn_prev_r  <= 1'b0;
    end else begin
      sck_sync_r  <= {sck_sync_r[SYNC_STAGES-2:0], i_sck};
      csn_sync_r  <= {csn_sync_r[SYNC_STAGES-2:0], i_csn};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], i_mosi};
      sck_prev_r  <= sck_s;
      csn_prev_r  <= csn_s;
    end
  end

  // Decode of address completion, commit request, error events and commit copy.
  // A csn rise takes priority over an SCK edge in the same cycle (abort wins).
  always_comb begin
    addr_next_s  = {addr_r, mosi_s};
    data_next_s  = {data_r, mosi_s};
    addr_done_s  = 1'b0;
    commit_dec_s = 1'b0;
    err_set_s    = 1'b0;
    copy_s       = pending_r & i_sync;
    if ((state_r == ST_ADDR) && sck_rise_s && !csn_rise_s &&
        (bit_cnt_r == CNT_W'(7))) begin
      addr_done_s = 1'b1;
    end else begin
      addr_done_s = 1'b0;
    end
    if (addr_done_s && (addr_next_s == 8'h80)) begin
      commit_dec_s = 1'b1;
    end else begin
      commit_dec_s = 1'b0;
    end
    if (csn_rise_s && ((state_r == ST_ADDR) || (state_r == ST_DATA))) begin
      err_set_s = 1'b1;
    end else if (addr_done_s && (addr_next_s >= 8'd10) && (addr_next_s != 8'h80)) begin
      err_set_s = 1'b1;
    end else begin
      err_set_s = 1'b0;
    end
  end

  // Frame FSM: address/data shifting and shadow bank writes.
  always_ff @(posedge i_mck) begin
    if (i_rst) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= '0;
      addr_r    <= '0;
      idx_r     <= '0;
      data_r    <= '0;
      for (int i = 0; i < 10; i++) begin
        shadow_r[i] <= '0;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (csn_fall_s) begin
            state_r   <= ST_ADDR;
            bit_cnt_r <= '0;
          end
        end
        ST_ADDR: begin
          if (csn_rise_s) begin
            state_r <= ST_IDLE;
          end else if (sck_rise_s) begin
            addr_r <= addr_next_s[6:0];
            if (addr_done_s) begin
              bit_cnt_r <= '0;
              idx_r     <= addr_next_s[3:0];
              if (addr_next_s < 8'd10) begin
                state_r <= ST_DATA;
              end else begin
                state_r <= ST_WAIT_CS;
              end
            end else begin
              bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            end
          end
        end
        ST_DATA: begin
          if (csn_rise_s) begin
            state_r <= ST_IDLE;
          end else if (sck_rise_s) begin
            data_r <= data_next_s[NBITS-2:0];
            if (bit_cnt_r == CNT_W'(NBITS - 1)) begin
              shadow_r[idx_r] <= data_next_s;
              bit_cnt_r       <= '0;
              state_r         <= ST_WAIT_CS;
            end else begin
              bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            end
          end
        end
        ST_WAIT_CS: begin
          if (csn_s) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Status flags. A new commit or a new error in the copy cycle is kept, since
  // it refers to a frame newer than the one being committed.
  always_ff @(posedge i_mck) begin
    if (i_rst) begin
      pending_r <= 1'b0;
      loaded_r  <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      if (commit_dec_s) begin
        pending_r <= 1'b1;
      end else if (copy_s) begin
        pending_r <= 1'b0;
      end
      if (err_set_s) begin
        err_r <= 1'b1;
      end else if (copy_s) begin
        err_r <= 1'b0;
      end
      if (copy_s) begin
        loaded_r <= 1'b1;
      end
    end
  end

  // Active bank: copied from the (pre-write) shadow bank only on a commit.
  always_ff @(posedge i_mck) begin
    if (i_rst) begin
      for (int i = 0; i < 10; i++) begin
        active_r[i] <= '0;
      end
    end else if (copy_s) begin
      for (int i = 0; i < 10; i++) begin
        active_r[i] <= shadow_r[i];
      end
    end
  end

  assign o_lp_a0   = active_r[0];
  assign o_lp_a1   = active_r[1];
  assign o_lp_a2   = active_r[2];
  assign o_lp_b1   = active_r[3];
  assign o_lp_b2   = active_r[4];
  assign o_hp_a0   = active_r[5];
  assign o_hp_a1   = active_r[6];
  assign o_hp_a2   = active_r[7];
  assign o_hp_b1   = active_r[8];
  assign o_hp_b2   = active_r[9];
  assign o_pending = pending_r;
  assign o_loaded  = loaded_r;
  assign o_err     = err_r;

endmodule

// File: doc/xover_coeff_loader.md
Name: xover_coeff_loader

Overview:
- SPI-slave coefficient loader sitting directly upstream of the audio crossover top level.
- Drives its ten biquad coefficient buses: LPF a0/a1/a2/b1/b2 and HPF a0/a1/a2/b1/b2.
- Host writes coefficients serially into a shadow bank, then issues a commit.
- The commit copies shadow to active on the next sample-sync pulse, so both IIR channels see an atomic coefficient change between samples.

Parameters:
- NBITS, 32: coefficient width (matches c_IIR_NBITS).
- SYNC_STAGES, 2: synchroniser flops on i_sck, i_csn, i_mosi.

Ports:
- i_mck  in  1  system clock; all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_sck  in  1  SPI clock, asynchronous; frequency ≤ i_mck/8.
- i_csn  in  1  SPI chip select, active low, asynchronous.
- i_mosi  in  1  SPI data, asynchronous.
- i_sync  in  1  one-i_mck-cycle sample-valid pulse (same pulse fed to the IIR filters).
- o_lp_a0, o_lp_a1, o_lp_a2, o_lp_b1, o_lp_b2  out  NBITS each  active LPF coefficients, signed.
- o_hp_a0, o_hp_a1, o_hp_a2, o_hp_b1, o_hp_b2  out  NBITS each  active HPF coefficients, signed.
- o_pending  out  1  commit requested, waiting for i_sync.
- o_loaded  out  1  at least one commit has completed since reset.
- o_err  out  1  sticky; set by an aborted frame or a bad address; cleared by reset or a commit.

Behaviour:
- Reset: all active and shadow registers = 0; o_pending = o_loaded = o_err = 0; FSM in IDLE; bit counter = 0.
- Input sync: i_sck, i_csn, i_mosi each pass through SYNC_STAGES flops.
  - SCK rise is detected on the synchronised edge.
  - MOSI is sampled on that detected rise (SPI mode 0, MSB first).
- Frame format: 8-bit address byte, then NBITS data bits for addresses 0x00–0x09.
  - 0x00–0x04: lp_a0, lp_a1, lp_a2, lp_b1, lp_b2.
  - 0x05–0x09: hp_a0, hp_a1, hp_a2, hp_b1, hp_b2.
  - 0x80 = COMMIT; no data bits follow.
- FSM states: IDLE, ADDR, DATA, WAIT_CS.
  - IDLE: synchronised csn falling edge → ADDR; bit counter cleared.
  - ADDR: shift 8 bits, then decode:
    - 0x00–0x09 → DATA.
    - 0x80 → set o_pending, go to WAIT_CS.
    - Any other value → set o_err, go to WAIT_CS.
  - DATA: shift NBITS bits into a holding register. After the last bit, write the holding register to the addressed shadow register in the same cycle, then go to WAIT_CS.
  - WAIT_CS: further SCK edges are ignored; csn high → IDLE.
  - Synchronised csn rising in ADDR or DATA (frame aborted) → o_err = 1, no shadow write, go to IDLE.
- Commit:
  - On the first i_mck cycle where o_pending = 1 and i_sync = 1, copy all ten shadow registers to active.
  - Active outputs change on the edge following that cycle (1-cycle latency from i_sync).
  - Same edge: o_pending → 0, o_loaded → 1, o_err → 0.
- Simultaneous events:
  - COMMIT decode and i_sync in the same cycle: no copy that cycle; the copy waits for the next i_sync.
  - Shadow write and commit copy in the same cycle: the copy uses the pre-write shadow value.
- Repeated COMMIT while pending: o_pending stays 1; still a single copy.
- Active registers change only on a commit, never on shadow writes.
- Reset mid-frame: immediate return to IDLE, every register back to its reset value; the rest of the frame is ignored until the next csn falling edge.

Test Plan:
- Reset, then no SPI activity → all ten coefficient outputs = 0, o_loaded = 0, o_pending = 0, o_err = 0.
- Write addr 0x00 data 0x0012_3456, write addr 0x09 data 0xFFFF_FF00, COMMIT, pulse i_sync 3 cycles after csn rises:
  - Before the pulse: outputs still 0, o_pending = 1.
  - One cycle after the pulse: o_lp_a0 = 0x00123456, o_hp_b2 = 0xFFFFFF00, o_pending = 0, o_loaded = 1.
- Write addr 0x03 = 0x4000_0000 with no COMMIT, several i_sync pulses → o_lp_b1 unchanged (0).
  - Then COMMIT plus i_sync → o_lp_b1 = 0x40000000.
- Raise csn after 20 of 40 bits of a write to addr 0x05 → o_err = 1 and shadow hp_a0 unchanged.
  - A following COMMIT plus i_sync leaves o_hp_a0 at its previous value and clears o_err.
- Address 0x0A with data bits → o_err = 1, no shadow register modified, FSM back to IDLE after csn rises.
- Assert i_rst midway through a data frame, then send a full valid frame with commit → frame accepted normally, values correct.
